// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: two-port req/gnt arbiter (port 1 priority, starvation guard for port 0)
// driving one outstanding AXI-lite read or write on the shared memory port.
module mem_req_scheduler #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_gnt,
    output logic                m0_rsp_vld,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_rsp_vld,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   axi_AW_ADDR,
    output logic                axi_AW_VALID,
    input  logic                axi_AW_READY,
    output logic [DATA_W-1:0]   axi_W_DATA,
    output logic [DATA_W/8-1:0] axi_W_STRB,
    output logic                axi_W_VALID,
    input  logic                axi_W_READY,
    input  logic                axi_B_VALID,
    output logic                axi_B_READY,
    output logic [ADDR_W-1:0]   axi_AR_ADDR,
    output logic                axi_AR_VALID,
    input  logic                axi_AR_READY,
    input  logic [DATA_W-1:0]   axi_R_DATA,
    input  logic                axi_R_VALID,
    output logic                axi_R_READY
);
    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t              r_state;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic [7:0]          r_starve;
    logic                r_arvalid;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_rready;
    logic                r_bready;
    logic                r_rsp0;
    logic                r_rsp1;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_we;
    logic w_aw_done;
    logic w_w_done;

    // Gated by rst_n so no grant is ever visible while reset is held.
    assign w_idle    = rst_n && r_state == IDLE;
    assign w_gnt0    = w_idle && m0_req && (!m1_req || r_starve == SMAX);
    assign w_gnt1    = w_idle && m1_req && !w_gnt0;
    assign w_we      = w_gnt1 ? m1_we : m0_we;
    assign w_aw_done = !r_awvalid || axi_AW_READY;
    assign w_w_done  = !r_wvalid || axi_W_READY;

    assign m0_gnt       = w_gnt0;
    assign m1_gnt       = w_gnt1;
    assign m0_rsp_vld   = r_rsp0;
    assign m1_rsp_vld   = r_rsp1;
    assign m0_rdata     = r_rdata0;
    assign m1_rdata     = r_rdata1;
    assign axi_AW_ADDR  = r_addr;
    assign axi_AR_ADDR  = r_addr;
    assign axi_W_DATA   = r_wdata;
    assign axi_W_STRB   = r_wstrb;
    assign axi_AW_VALID = r_awvalid;
    assign axi_W_VALID  = r_wvalid;
    assign axi_AR_VALID = r_arvalid;
    assign axi_R_READY  = r_rready;
    assign axi_B_READY  = r_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!m0_req || w_gnt0) begin
            r_starve <= '0;
        end else if (w_gnt1 && r_starve != SMAX) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_arvalid <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_rready  <= 1'b0;
            r_bready  <= 1'b0;
            r_rsp0    <= 1'b0;
            r_rsp1    <= 1'b0;
        end else begin
            r_rsp0 <= 1'b0;
            r_rsp1 <= 1'b0;
            case (r_state)
                IDLE: if (w_gnt0 || w_gnt1) begin
                    r_owner   <= w_gnt1;
                    r_addr    <= w_gnt1 ? m1_addr : m0_addr;
                    r_wdata   <= w_gnt1 ? m1_wdata : m0_wdata;
                    r_wstrb   <= w_gnt1 ? m1_wstrb : m0_wstrb;
                    r_arvalid <= !w_we;
                    r_awvalid <= w_we;
                    r_wvalid  <= w_we;
                    r_state   <= w_we ? WR_REQ : RD_ADDR;
                end
                RD_ADDR: if (axi_AR_READY) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= RD_DATA;
                end
                RD_DATA: if (axi_R_VALID) begin
                    r_rready <= 1'b0;
                    r_rdata0 <= r_owner ? r_rdata0 : axi_R_DATA;
                    r_rdata1 <= r_owner ? axi_R_DATA : r_rdata1;
                    r_rsp0   <= !r_owner;
                    r_rsp1   <= r_owner;
                    r_state  <= IDLE;
                end
                WR_REQ: begin
                    if (axi_AW_READY) r_awvalid <= 1'b0;
                    if (axi_W_READY) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: if (axi_B_VALID) begin
                    r_bready <= 1'b0;
                    r_rsp0   <= !r_owner;
                    r_rsp1   <= r_owner;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler: directed scenario tasks with hand-computed expectations;
// inputs change 1ns after the rising edge, outputs are sampled 3ns after it.
module tb_mem_req_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [63:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [7:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_gnt, m0_rsp_vld, m1_gnt, m1_rsp_vld;
    logic [63:0] m0_rdata, m1_rdata;
    logic [63:0] axi_AW_ADDR, axi_AR_ADDR, axi_W_DATA;
    logic [7:0]  axi_W_STRB;
    logic        axi_AW_VALID, axi_W_VALID, axi_B_READY, axi_AR_VALID, axi_R_READY;
    logic        axi_AW_READY = 0, axi_W_READY = 0, axi_B_VALID = 0, axi_AR_READY = 0, axi_R_VALID = 0;
    logic [63:0] axi_R_DATA = '0;
    int errors = 0;
    int checks = 0;

    mem_req_scheduler #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(m0_gnt), .m0_rsp_vld(m0_rsp_vld), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(m1_gnt), .m1_rsp_vld(m1_rsp_vld), .m1_rdata(m1_rdata),
        .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID), .axi_AW_READY(axi_AW_READY),
        .axi_W_DATA(axi_W_DATA), .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID), .axi_W_READY(axi_W_READY),
        .axi_B_VALID(axi_B_VALID), .axi_B_READY(axi_B_READY),
        .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
        .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        m0_req = 1;
        repeat (3) @(posedge clk);
        #3;
        checks++; if ({m0_gnt, m1_gnt, m0_rsp_vld, m1_rsp_vld} !== 4'b0) begin errors++; $display("FAIL reset_gnt_rsp: got %b exp 0000", {m0_gnt, m1_gnt, m0_rsp_vld, m1_rsp_vld}); end
        checks++; if ({axi_AW_VALID, axi_W_VALID, axi_B_READY, axi_AR_VALID, axi_R_READY} !== 5'b0) begin errors++; $display("FAIL reset_axi: got %b exp 00000", {axi_AW_VALID, axi_W_VALID, axi_B_READY, axi_AR_VALID, axi_R_READY}); end
        checks++; if ({m0_rdata, m1_rdata, axi_AR_ADDR, axi_W_DATA} !== '0) begin errors++; $display("FAIL reset_regs: rdata0 %h rdata1 %h ar %h wd %h exp 0", m0_rdata, m1_rdata, axi_AR_ADDR, axi_W_DATA); end
        m0_req = 0;
        step;
        rst_n = 1;
    endtask

    task automatic test_p0_read;
        m0_req = 1; m0_we = 0; m0_addr = 64'h8000_0000; #2;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rd0_gnt: got %b exp 10", {m0_gnt, m1_gnt}); end
        step; m0_req = 0; axi_AR_READY = 1; #2;
        checks++; if ({axi_AR_VALID, axi_R_READY} !== 2'b10) begin errors++; $display("FAIL rd0_ar_valid: got %b exp 10", {axi_AR_VALID, axi_R_READY}); end
        checks++; if (axi_AR_ADDR !== 64'h8000_0000) begin errors++; $display("FAIL rd0_ar_addr: got %h exp 80000000", axi_AR_ADDR); end
        step; axi_AR_READY = 0; axi_R_VALID = 1; axi_R_DATA = 64'hDEAD_BEEF_0123_4567; #2;
        checks++; if ({axi_AR_VALID, axi_R_READY, m0_rsp_vld} !== 3'b010) begin errors++; $display("FAIL rd0_rdata_phase: got %b exp 010", {axi_AR_VALID, axi_R_READY, m0_rsp_vld}); end
        step; axi_R_VALID = 0; #2;
        checks++; if ({m0_rsp_vld, m1_rsp_vld, axi_R_READY} !== 3'b100) begin errors++; $display("FAIL rd0_rsp: got %b exp 100", {m0_rsp_vld, m1_rsp_vld, axi_R_READY}); end
        checks++; if (m0_rdata !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL rd0_rdata: got %h exp deadbeef01234567", m0_rdata); end
        checks++; if (m1_rdata !== 64'h0) begin errors++; $display("FAIL rd0_m1_rdata_quiet: got %h exp 0", m1_rdata); end
        step; #2;
        checks++; if (m0_rsp_vld !== 1'b0 || m0_rdata !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL rd0_after: rsp %b rdata %h exp 0 deadbeef01234567", m0_rsp_vld, m0_rdata); end
        step;
    endtask

    task automatic test_p1_write;
        m1_req = 1; m1_we = 1; m1_addr = 64'h100; m1_wdata = 64'h1122_3344_5566_7788; m1_wstrb = 8'h0F; #2;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL wr1_gnt: got %b exp 01", {m0_gnt, m1_gnt}); end
        step; m1_req = 0; axi_AW_READY = 1; #2;
        checks++; if ({axi_AW_VALID, axi_W_VALID, axi_AR_VALID} !== 3'b110) begin errors++; $display("FAIL wr1_valids: got %b exp 110", {axi_AW_VALID, axi_W_VALID, axi_AR_VALID}); end
        checks++; if (axi_AW_ADDR !== 64'h100 || axi_W_DATA !== 64'h1122_3344_5566_7788 || axi_W_STRB !== 8'h0F) begin errors++; $display("FAIL wr1_payload: got %h %h %h exp 100 1122334455667788 0f", axi_AW_ADDR, axi_W_DATA, axi_W_STRB); end
        step; axi_AW_READY = 0; #2;
        checks++; if ({axi_AW_VALID, axi_W_VALID} !== 2'b01) begin errors++; $display("FAIL wr1_aw_drop: got %b exp 01", {axi_AW_VALID, axi_W_VALID}); end
        step; #2;
        checks++; if ({axi_AW_VALID, axi_W_VALID, axi_B_READY} !== 3'b010) begin errors++; $display("FAIL wr1_w_hold: got %b exp 010", {axi_AW_VALID, axi_W_VALID, axi_B_READY}); end
        step; axi_W_READY = 1; #2;
        checks++; if (axi_W_VALID !== 1'b1) begin errors++; $display("FAIL wr1_w_hs: got %b exp 1", axi_W_VALID); end
        step; axi_W_READY = 0; axi_B_VALID = 1; #2;
        checks++; if ({axi_W_VALID, axi_B_READY, m1_rsp_vld} !== 3'b010) begin errors++; $display("FAIL wr1_bresp: got %b exp 010", {axi_W_VALID, axi_B_READY, m1_rsp_vld}); end
        step; axi_B_VALID = 0; #2;
        checks++; if ({m0_rsp_vld, m1_rsp_vld, axi_B_READY} !== 3'b010) begin errors++; $display("FAIL wr1_rsp: got %b exp 010", {m0_rsp_vld, m1_rsp_vld, axi_B_READY}); end
        step; #2;
        checks++; if (m1_rsp_vld !== 1'b0) begin errors++; $display("FAIL wr1_rsp_once: got %b exp 0", m1_rsp_vld); end
        step;
    endtask

    task automatic test_starve;
        int exp_o [6] = '{1, 1, 0, 1, 1, 0};
        m0_req = 1; m0_we = 0; m0_addr = 64'h10;
        m1_req = 1; m1_we = 0; m1_addr = 64'h20;
        axi_AR_READY = 1; axi_R_VALID = 1; axi_R_DATA = 64'h55; #2;
        for (int g = 0; g < 6; g++) begin
            int n = 0;
            while (!(m0_gnt || m1_gnt) && n < 8) begin step; #2; n++; end
            checks++;
            if (!(m0_gnt || m1_gnt)) begin errors++; $display("FAIL starve_timeout[%0d]: no grant within 8 cycles", g); end
            else if ({m0_gnt, m1_gnt} !== (exp_o[g] == 1 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL starve_order[%0d]: got m0/m1 %b exp port %0d", g, {m0_gnt, m1_gnt}, exp_o[g]); end
            step; #2;
        end
        m0_req = 0; m1_req = 0;
        repeat (4) step;
        axi_AR_READY = 0; axi_R_VALID = 0;
    endtask

    task automatic test_rwait;
        m0_req = 1; m0_we = 0; m0_addr = 64'h40; #2;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rwait_gnt: got %b exp 1", m0_gnt); end
        step; m0_req = 0; axi_AR_READY = 1;
        step; axi_AR_READY = 0; m0_req = 1; m1_req = 1;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++; if ({axi_R_READY, m0_gnt, m1_gnt, m0_rsp_vld, m1_rsp_vld} !== 5'b10000) begin errors++; $display("FAIL rwait_hold[%0d]: got %b exp 10000", i, {axi_R_READY, m0_gnt, m1_gnt, m0_rsp_vld, m1_rsp_vld}); end
            step;
        end
        axi_R_VALID = 1; axi_R_DATA = 64'h0BAD_F00D; m0_req = 0; m1_req = 0; #2;
        checks++; if ({axi_R_READY, m0_rsp_vld} !== 2'b10) begin errors++; $display("FAIL rwait_hs: got %b exp 10", {axi_R_READY, m0_rsp_vld}); end
        step; axi_R_VALID = 0; #2;
        checks++; if (m0_rsp_vld !== 1'b1 || m0_rdata !== 64'h0BAD_F00D) begin errors++; $display("FAIL rwait_rsp: rsp %b rdata %h exp 1 0badf00d", m0_rsp_vld, m0_rdata); end
        step;
    endtask

    task automatic test_reset_mid;
        m0_req = 1; m0_we = 0; m0_addr = 64'h80;
        step; m0_req = 0; axi_AR_READY = 1;
        step; axi_AR_READY = 0; #2;
        checks++; if (axi_R_READY !== 1'b1) begin errors++; $display("FAIL rstmid_in_rdata: got %b exp 1", axi_R_READY); end
        rst_n = 0; axi_R_VALID = 1; axi_R_DATA = 64'hFFFF; #1;
        checks++; if ({axi_R_READY, axi_AR_VALID, axi_AW_VALID, axi_W_VALID, axi_B_READY, m0_gnt, m1_gnt, m0_rsp_vld, m1_rsp_vld} !== 9'b0) begin errors++; $display("FAIL rstmid_outputs: got %b exp 0", {axi_R_READY, axi_AR_VALID, axi_AW_VALID, axi_W_VALID, axi_B_READY, m0_gnt, m1_gnt, m0_rsp_vld, m1_rsp_vld}); end
        checks++; if (m0_rdata !== 64'h0 || m1_rdata !== 64'h0) begin errors++; $display("FAIL rstmid_rdata: got %h %h exp 0 0", m0_rdata, m1_rdata); end
        step; step;
        rst_n = 1; axi_R_VALID = 0; #2;
        checks++; if ({m0_rsp_vld, m1_rsp_vld} !== 2'b0) begin errors++; $display("FAIL rstmid_stale0: got %b exp 00", {m0_rsp_vld, m1_rsp_vld}); end
        step; #2;
        checks++; if ({m0_rsp_vld, m1_rsp_vld, axi_R_READY} !== 3'b0) begin errors++; $display("FAIL rstmid_stale1: got %b exp 000", {m0_rsp_vld, m1_rsp_vld, axi_R_READY}); end
        step; m1_req = 1; m1_we = 0; m1_addr = 64'h200; #2;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL rstmid_gnt: got %b exp 01", {m0_gnt, m1_gnt}); end
        step; m1_req = 0; axi_AR_READY = 1; #2;
        checks++; if (axi_AR_VALID !== 1'b1 || axi_AR_ADDR !== 64'h200) begin errors++; $display("FAIL rstmid_ar: valid %b addr %h exp 1 200", axi_AR_VALID, axi_AR_ADDR); end
        step; axi_AR_READY = 0; axi_R_VALID = 1; axi_R_DATA = 64'hCAFE;
        step; axi_R_VALID = 0; #2;
        checks++; if ({m0_rsp_vld, m1_rsp_vld} !== 2'b01 || m1_rdata !== 64'hCAFE || m0_rdata !== 64'h0) begin errors++; $display("FAIL rstmid_rsp: rsp %b rdata1 %h rdata0 %h exp 01 cafe 0", {m0_rsp_vld, m1_rsp_vld}, m1_rdata, m0_rdata); end
        step;
    endtask

    task automatic test_back_to_back;
        m0_req = 1; m0_we = 0; m0_addr = 64'h300;
        axi_AR_READY = 1; axi_R_VALID = 1; axi_R_DATA = 64'h1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) axi_R_DATA = 64'h2222;
            if (c == 7) m0_req = 0;
            #2;
            checks++; if (m0_gnt !== ((c % 3 == 0) && c <= 6)) begin errors++; $display("FAIL b2b_gnt[c%0d]: got %b exp %b", c, m0_gnt, (c % 3 == 0) && c <= 6); end
            checks++; if (m0_rsp_vld !== (c == 3 || c == 6 || c == 9)) begin errors++; $display("FAIL b2b_rsp[c%0d]: got %b exp %b", c, m0_rsp_vld, c == 3 || c == 6 || c == 9); end
            if (c == 3) begin checks++; if (m0_rdata !== 64'h1111) begin errors++; $display("FAIL b2b_rdata1: got %h exp 1111", m0_rdata); end end
            if (c == 6) begin checks++; if (m0_rdata !== 64'h2222) begin errors++; $display("FAIL b2b_rdata2: got %h exp 2222", m0_rdata); end end
            step;
        end
        axi_AR_READY = 0; axi_R_VALID = 0;
        step;
    endtask

    initial begin
        test_reset;
        test_p0_read;
        test_p1_write;
        test_starve;
        test_rwait;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Two-requester memory scheduler and AXI-lite master for the single-issue core. Instruction fetch (port 0) and load/store (port 1) each issue simple req/gnt memory requests; the block picks one, runs exactly one AXI-lite read or write transaction on the shared memory port, and returns the response to the owner. Port 1 has fixed priority, with a starvation guard that forces a port-0 grant. It sits between the IFU/EXU request logic and the memory-side interconnect.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- STARVE_MAX, 8, consecutive port-1 grants allowed while port 0 waits (range 1..255)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  request valid; held with payload stable until gnt
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address, passed through unmodified
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_wstrb / m1_wstrb  in  DATA_W/8  write byte enables
- m0_gnt / m1_gnt  out  1  request accepted this cycle
- m0_rsp_vld / m1_rsp_vld  out  1  one-cycle response pulse (read data or write done)
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with rsp_vld
- axi_AW_ADDR  out  ADDR_W;  axi_AW_VALID  out  1;  axi_AW_READY  in  1
- axi_W_DATA  out  DATA_W;  axi_W_STRB  out  DATA_W/8;  axi_W_VALID  out  1;  axi_W_READY  in  1
- axi_B_VALID  in  1;  axi_B_READY  out  1
- axi_AR_ADDR  out  ADDR_W;  axi_AR_VALID  out  1;  axi_AR_READY  in  1
- axi_R_DATA  in  DATA_W;  axi_R_VALID  in  1;  axi_R_READY  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. One transaction outstanding.
- IDLE arbitration: only m0_req → port 0; only m1_req → port 1; both → port 1 unless starve_cnt == STARVE_MAX, then port 0.
- Grant: gnt of the winner is asserted combinationally in the IDLE cycle; at the clock edge owner, we, addr, wdata, wstrb are latched and state moves to RD_ADDR (read) or WR_REQ (write). gnt is never asserted outside IDLE, and never for both ports.
- starve_cnt (8 bit, saturating at STARVE_MAX): +1 on each port-1 grant while m0_req is high; cleared on any port-0 grant or on any cycle m0_req is low.
- RD_ADDR: AR_VALID=1 with latched addr; on AR_READY → RD_DATA.
- RD_DATA: R_READY=1; on R_VALID capture R_DATA into owner rdata register, pulse owner rsp_vld next cycle, → IDLE.
- WR_REQ: AW_VALID and W_VALID asserted together; each drops independently after its own handshake; when both are done (same or different cycles) → WR_RESP.
- WR_RESP: B_READY=1; on B_VALID pulse owner rsp_vld next cycle, → IDLE. B response code is not checked.
- Zero wstrb writes are still issued. rdata of the non-owner port holds its last value.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, all axi_*_VALID/READY 0, all gnt/rsp_vld 0, rdata 0, starve_cnt 0, latched payload 0. Reset mid-transaction abandons it; no rsp_vld is ever produced for it.
- Read, zero slave wait: grant cycle T, AR_VALID at T+1, R_VALID accepted at T+2, rsp_vld at T+3. Write, zero wait: grant T, AW/W at T+1, B at T+2, rsp_vld at T+3.
- rsp_vld cycle coincides with IDLE, so the next grant may occur in the same cycle as the previous response pulse.
- VALIDs are registered outputs and never drop before handshake. R_READY/B_READY are high only in RD_DATA/WR_RESP.

## Test plan
- Port-0 read 0x8000_0000, slave returns 0xDEAD_BEEF_0123_4567 with 0 waits → m0_gnt at T, AR at T+1, m0_rsp_vld at T+3 with that rdata; m1 outputs quiet.
- Port-1 write addr 0x100, wdata 0x1122334455667788, wstrb 0x0F; AW_READY at T+1, W_READY delayed to T+4 → AW_VALID drops after T+1, W_VALID held to T+4, B accepted, m1_rsp_vld once.
- STARVE_MAX=2, both ports requesting continuously → grant order 1,1,0,1,1,0; starve_cnt returns to 0 after each port-0 grant.
- R_VALID held low 5 cycles in RD_DATA → R_READY stays 1, no gnt either port, rsp_vld only after R handshake.
- rst_n pulsed low during RD_DATA → all outputs 0 immediately; after release, a new port-1 read completes normally with no stale rsp_vld.
- Back-to-back port-0 reads with m0_req held → second gnt in the same cycle as first rsp_vld; 3-cycle throughput per read.
